beta_update: RTL and testbench
==============================

Name: beta_update

Overview:
- Beta-update processing array of the SCAN polar decoder (N=1024, P=64, Q=6).
- Combines left-child beta, right-child beta and the node's stored LLRs into parent-node beta messages.
- Emits one 2*P*Q-wide write per chunk, with aligned layer, address and count fields, directly into the beta storage RAM write port (b_in, layer_w, w_address, cnta, w_en).
- Fixed 2-cycle pipeline, no backpressure; carries a saturation-event counter for BER/quantisation debug.

Parameters:
- P, 64, lanes per half-chunk (PEs per half)
- Q, 6, LLR/beta bit width, two's complement
- SATW, 16, saturation event counter width

Ports:
- clk  in  1  clock, all flops on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input chunk valid
- in_layer  in  5  layer of parent node (1 = bottom)
- in_address  in  9  node write address, passed through
- in_cnt  in  4  chunk index within node, passed through
- in_last  in  1  last chunk of node, passed through
- beta_l  in  P*Q  left-child beta, lane i at [i*Q+:Q]
- beta_r  in  P*Q  right-child beta
- llr_l  in  P*Q  node LLR, upper half
- llr_r  in  P*Q  node LLR, lower half
- sat_clr  in  1  synchronous clear of sat_cnt
- b_out  out  2*P*Q  [P*Q-1:0] = first-half results, [2*P*Q-1:P*Q] = second-half results
- w_en  out  1  write strobe for beta RAM
- layer_w  out  5  aligned in_layer
- w_address  out  9  aligned in_address
- cnta  out  4  aligned in_cnt
- node_done  out  1  aligned in_last AND w_en
- layer_err  out  1  1-cycle pulse, aligned, when the input layer was illegal
- sat_cnt  out  SATW  count of output cycles with at least one saturated lane

Behaviour:
- Reset (rst=0, asynchronous):
  - All pipeline registers and outputs go to 0 immediately, including any in-flight data; w_en=0 within the same cycle.
  - sat_cnt=0.
- Input clamp: any lane value -2^(Q-1) (-32) is treated as -(2^(Q-1)-1) (-31). All arithmetic is symmetric-saturating to ±(2^(Q-1)-1).
- f(a,b) = sign(a)*sign(b)*min(|a|,|b|), with sign(0)=+.
- Stage 1 (registered when in_valid=1): s[i] = sat(beta_r[i] + llr_r[i]), computed at Q+1 bits then clamped. Stage 1 also registers beta_l, beta_r, llr_l and the sideband fields.
- Stage 2 (registered):
  - lo[i] = f(beta_l[i], s[i])
  - hi[i] = sat(f(beta_l[i], llr_l[i]) + beta_r[i])
  - b_out = {hi, lo}
- Latency: w_en and b_out appear exactly 2 cycles after in_valid. Throughput is 1 chunk/cycle; back-to-back valids produce back-to-back w_en.
- Bubbles: when in_valid=0, a bubble propagates; the corresponding w_en=0 and b_out=0.
- Lane masking: active lanes per half M = min(2^(in_layer-1), P). Lanes i ≥ M are forced to 0 in both halves (layer 1: M=1; layer 7 and above: M=64).
- Illegal layer (in_layer=0 or >8):
  - Data is still computed, but w_en=0 and node_done=0 for that slot.
  - layer_err=1 for that slot.
  - sat_cnt is not incremented.
- Saturation counting:
  - A stage-1 or stage-2 clamp on any active lane of a valid slot increments sat_cnt by 1 in the cycle w_en is asserted.
  - sat_cnt saturates at all-ones; it does not wrap.
  - sat_clr has priority over an increment in the same cycle (result 0).
- No internal FSM beyond the valid pipeline. The sideband fields (layer, address, cnt, last) are carried in the same registers as the data, so they can never misalign.

Decomposition:
- Shared package holds:
  - P, Q
  - QMAX = 2^(Q-1)-1
  - a sat_add function (Q+1 to Q)
  - an f_minsum function
  - the lane-mask function of layer
- One sub-module, beta_pe: a single-lane stage-1/stage-2 datapath with a sat flag output, instantiated P times via generate.
- The top level holds the sideband pipeline, masking, error logic and sat_cnt.

Test Plan:
- Arithmetic: in_layer=8, all lanes beta_l=5, beta_r=4, llr_r=-7, llr_l=10 -> 2 cycles later w_en=1, every lo lane=-3, every hi lane=9, sat_cnt stays 0.
- Saturation: beta_r=31, llr_r=20, beta_l=-31, llr_l=-31 -> lo=-31, hi=31 (62 clamped), sat_cnt 0->1. Input -32 is treated as -31 and gives identical results.
- Masking: in_layer=2, all lanes beta_l=5, beta_r=4, llr_r=-7, llr_l=10 -> lanes 0-1 of each half nonzero (lo=-3, hi=9), lanes 2-63 of both halves =0.
- Streaming: 4 back-to-back valids with in_address=3, in_cnt=0..3, in_last on the 4th -> w_en high for 4 consecutive cycles starting at cycle 2, cnta=0..3 in order, w_address=3, node_done only on the 4th; then a 1-cycle bubble gives w_en=0.
- Error and counter: in_layer=9 -> layer_err pulses at cycle 2, w_en=0. sat_cnt preset to 0xFFFF with further saturations -> holds 0xFFFF. sat_clr together with a saturating slot -> sat_cnt=0.
- Reset mid-flight: assert rst=0 one cycle after in_valid -> w_en and b_out drop to 0 asynchronously, and no write emerges after release.

Source files
------------

// File: rtl/beta_update_pkg.sv
// Shared constants, types and saturating min-sum helpers for the SCAN
// polar decoder beta-update array (N=1024, P=64 lanes per half, Q=6 bits).
package beta_update_pkg;

    localparam int P     = 64;
    localparam int Q     = 6;
    localparam int LAYW  = 5;
    localparam int ADDRW = 9;
    localparam int CNTW  = 4;

    localparam logic [LAYW-1:0] LAYER_TOP = 5'd8;

    localparam logic [Q-1:0] QMAX = {1'b0, {(Q-1){1'b1}}};
    localparam logic [Q-1:0] QMIN = {1'b1, {(Q-2){1'b0}}, 1'b1};
    localparam logic [Q-1:0] QNEG = {1'b1, {(Q-1){1'b0}}};
    localparam logic [Q-1:0] QONE = {{(Q-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic         clip;
        logic [Q-1:0] val;
    } sat_res_t;

    typedef struct packed {
        logic             valid;
        logic [LAYW-1:0]  layer;
        logic [ADDRW-1:0] addr;
        logic [CNTW-1:0]  cnt;
        logic             last;
    } side_t;

    function automatic logic [Q-1:0] clamp_in(input logic [Q-1:0] x);
        logic [Q-1:0] r;
        if (x == QNEG) begin
            r = QMIN;
        end else begin
            r = x;
        end
        return r;
    endfunction

    function automatic logic [Q:0] sext(input logic [Q-1:0] x);
        return {x[Q-1], x};
    endfunction

    // A wide sum of -2^(Q-1) also clips, keeping the range symmetric.
    function automatic sat_res_t sat_add(input logic [Q:0] sum);
        sat_res_t r;
        if (sum[Q] != sum[Q-1]) begin
            r.clip = 1'b1;
            r.val  = sum[Q] ? QMIN : QMAX;
        end else if (sum[Q-1:0] == QNEG) begin
            r.clip = 1'b1;
            r.val  = QMIN;
        end else begin
            r.clip = 1'b0;
            r.val  = sum[Q-1:0];
        end
        return r;
    endfunction

    function automatic logic [Q-1:0] f_minsum(input logic [Q-1:0] a, input logic [Q-1:0] b);
        logic [Q-1:0] mag_a;
        logic [Q-1:0] mag_b;
        logic [Q-1:0] mag;
        mag_a = a[Q-1] ? (~a + QONE) : a;
        mag_b = b[Q-1] ? (~b + QONE) : b;
        mag   = (mag_a < mag_b) ? mag_a : mag_b;
        return (a[Q-1] ^ b[Q-1]) ? (~mag + QONE) : mag;
    endfunction

    function automatic logic layer_legal(input logic [LAYW-1:0] layer);
        return (layer != 5'd0) && (layer <= LAYER_TOP);
    endfunction

    // Layer 0 is illegal; it keeps a single lane so its data is still defined.
    function automatic logic [P-1:0] lane_mask(input logic [LAYW-1:0] layer);
        logic [P-1:0] m;
        int           active;
        case (layer)
            5'd0, 5'd1: active = 1;
            5'd2:       active = 2;
            5'd3:       active = 4;
            5'd4:       active = 8;
            5'd5:       active = 16;
            5'd6:       active = 32;
            default:    active = P;
        endcase
        for (int i = 0; i < P; i++) begin
            m[i] = (i < active);
        end
        return m;
    endfunction

endpackage

// File: rtl/beta_update_pe.sv
// Single-lane beta-update datapath: stage 1 forms sat(beta_r+llr_r), stage 2
// forms lo/hi results; sat flags clipping in either stage for the current slot.
module beta_pe
    import beta_update_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         keep,
    input  logic [Q-1:0] beta_l,
    input  logic [Q-1:0] beta_r,
    input  logic [Q-1:0] llr_l,
    input  logic [Q-1:0] llr_r,
    output logic [Q-1:0] lo,
    output logic [Q-1:0] hi,
    output logic         sat
);

    logic [Q-1:0] bl_c_s;
    logic [Q-1:0] br_c_s;
    logic [Q-1:0] ll_c_s;
    logic [Q-1:0] lr_c_s;
    sat_res_t     s_sum_s;
    logic [Q-1:0] bl_r;
    logic [Q-1:0] br_r;
    logic [Q-1:0] ll_r;
    logic [Q-1:0] s_r;
    logic         s_clip_r;
    logic [Q-1:0] lo_s;
    logic [Q-1:0] fl_s;
    sat_res_t     hi_sum_s;
    logic [Q-1:0] lo_r;
    logic [Q-1:0] hi_r;

    // Input clamp and stage-1 saturating sum.
    always_comb begin
        bl_c_s  = clamp_in(beta_l);
        br_c_s  = clamp_in(beta_r);
        ll_c_s  = clamp_in(llr_l);
        lr_c_s  = clamp_in(llr_r);
        s_sum_s = sat_add(sext(br_c_s) + sext(lr_c_s));
    end

    // Stage-1 operand registers, loaded only for valid chunks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bl_r     <= {Q{1'b0}};
            br_r     <= {Q{1'b0}};
            ll_r     <= {Q{1'b0}};
            s_r      <= {Q{1'b0}};
            s_clip_r <= 1'b0;
        end else if (load) begin
            bl_r     <= bl_c_s;
            br_r     <= br_c_s;
            ll_r     <= ll_c_s;
            s_r      <= s_sum_s.val;
            s_clip_r <= s_sum_s.clip;
        end
    end

    // Stage-2 min-sum combination.
    always_comb begin
        lo_s     = f_minsum(bl_r, s_r);
        fl_s     = f_minsum(bl_r, ll_r);
        hi_sum_s = sat_add(sext(fl_s) + sext(br_r));
        sat      = s_clip_r | hi_sum_s.clip;
    end

    // Stage-2 result registers; masked lanes and bubbles emit zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_r <= {Q{1'b0}};
            hi_r <= {Q{1'b0}};
        end else begin
            lo_r <= keep ? lo_s : {Q{1'b0}};
            hi_r <= keep ? hi_sum_s.val : {Q{1'b0}};
        end
    end

    assign lo = lo_r;
    assign hi = hi_r;

endmodule

// File: rtl/beta_update.sv
// Beta-update array top: P lanes of beta_pe, sideband pipeline aligned with
// the data, lane masking by layer, illegal-layer flagging and sat event counter.
module beta_update
    import beta_update_pkg::*;
#(
    parameter int SATW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [LAYW-1:0]    in_layer,
    input  logic [ADDRW-1:0]   in_address,
    input  logic [CNTW-1:0]    in_cnt,
    input  logic               in_last,
    input  logic [P*Q-1:0]     beta_l,
    input  logic [P*Q-1:0]     beta_r,
    input  logic [P*Q-1:0]     llr_l,
    input  logic [P*Q-1:0]     llr_r,
    input  logic               sat_clr,
    output logic [2*P*Q-1:0]   b_out,
    output logic               w_en,
    output logic [LAYW-1:0]    layer_w,
    output logic [ADDRW-1:0]   w_address,
    output logic [CNTW-1:0]    cnta,
    output logic               node_done,
    output logic               layer_err,
    output logic [SATW-1:0]    sat_cnt
);

    localparam logic [SATW-1:0] SAT_FULL = {SATW{1'b1}};
    localparam logic [SATW-1:0] SAT_ONE  = {{(SATW-1){1'b0}}, 1'b1};
    localparam side_t           SIDE_IDLE = {$bits(side_t){1'b0}};

    side_t            side1_r;
    logic [P-1:0]     mask1_s;
    logic             legal1_s;
    logic             sat_inc_s;
    logic [P-1:0]     keep_s;
    logic [P-1:0]     sat_lane_s;
    logic [P*Q-1:0]   lo_bus_s;
    logic [P*Q-1:0]   hi_bus_s;
    logic             w_en_r;
    logic             node_done_r;
    logic             layer_err_r;
    logic [LAYW-1:0]  layer_w_r;
    logic [ADDRW-1:0] w_address_r;
    logic [CNTW-1:0]  cnta_r;
    logic [SATW-1:0]  sat_cnt_r;

    // Sideband stage 1; a bubble loads all-zero so stage 2 emits zeros for it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            side1_r <= SIDE_IDLE;
        end else if (in_valid) begin
            side1_r <= '{valid: 1'b1, layer: in_layer, addr: in_address,
                         cnt: in_cnt, last: in_last};
        end else begin
            side1_r <= SIDE_IDLE;
        end
    end

    // Stage-1 decode of the slot's layer into lane mask, legality and sat event.
    always_comb begin
        mask1_s   = lane_mask(side1_r.layer);
        legal1_s  = layer_legal(side1_r.layer);
        keep_s    = mask1_s & {P{side1_r.valid}};
        sat_inc_s = side1_r.valid & legal1_s & (|(sat_lane_s & mask1_s));
    end

    for (genvar i = 0; i < P; i++) begin : g_pe
        beta_pe u_pe (
            .clk    (clk),
            .rst    (rst),
            .load   (in_valid),
            .keep   (keep_s[i]),
            .beta_l (beta_l[i*Q +: Q]),
            .beta_r (beta_r[i*Q +: Q]),
            .llr_l  (llr_l[i*Q +: Q]),
            .llr_r  (llr_r[i*Q +: Q]),
            .lo     (lo_bus_s[i*Q +: Q]),
            .hi     (hi_bus_s[i*Q +: Q]),
            .sat    (sat_lane_s[i])
        );
    end

    // Stage-2 write-port sideband registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_en_r      <= 1'b0;
            node_done_r <= 1'b0;
            layer_err_r <= 1'b0;
            layer_w_r   <= {LAYW{1'b0}};
            w_address_r <= {ADDRW{1'b0}};
            cnta_r      <= {CNTW{1'b0}};
        end else begin
            w_en_r      <= side1_r.valid & legal1_s;
            node_done_r <= side1_r.valid & legal1_s & side1_r.last;
            layer_err_r <= side1_r.valid & ~legal1_s;
            layer_w_r   <= side1_r.layer;
            w_address_r <= side1_r.addr;
            cnta_r      <= side1_r.cnt;
        end
    end

    // Saturation event counter: clear wins, then saturating increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_cnt_r <= {SATW{1'b0}};
        end else if (sat_clr) begin
            sat_cnt_r <= {SATW{1'b0}};
        end else if (sat_inc_s && (sat_cnt_r != SAT_FULL)) begin
            sat_cnt_r <= sat_cnt_r + SAT_ONE;
        end
    end

    assign b_out     = {hi_bus_s, lo_bus_s};
    assign w_en      = w_en_r;
    assign node_done = node_done_r;
    assign layer_err = layer_err_r;
    assign layer_w   = layer_w_r;
    assign w_address = w_address_r;
    assign cnta      = cnta_r;
    assign sat_cnt   = sat_cnt_r;

endmodule

// File: tb/tb_beta_update.sv
// Scoreboard bench for beta_update: integer reference model fills an expected
// queue at issue time; a negedge monitor pops and compares on every output slot.
module tb_beta_update;

    localparam int P = 64;
    localparam int Q = 6;
    localparam int W = P * Q;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic [4:0]     in_layer = 5'd0;
    logic [8:0]     in_address = 9'd0;
    logic [3:0]     in_cnt = 4'd0;
    logic           in_last = 1'b0;
    logic [W-1:0]   beta_l = '0;
    logic [W-1:0]   beta_r = '0;
    logic [W-1:0]   llr_l = '0;
    logic [W-1:0]   llr_r = '0;
    logic           sat_clr = 1'b0;
    logic [2*W-1:0] b_out;
    logic           w_en;
    logic [4:0]     layer_w;
    logic [8:0]     w_address;
    logic [3:0]     cnta;
    logic           node_done;
    logic           layer_err;
    logic [15:0]    sat_cnt;

    always #5 clk = ~clk;

    beta_update dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_layer(in_layer),
        .in_address(in_address), .in_cnt(in_cnt), .in_last(in_last),
        .beta_l(beta_l), .beta_r(beta_r), .llr_l(llr_l), .llr_r(llr_r),
        .sat_clr(sat_clr), .b_out(b_out), .w_en(w_en), .layer_w(layer_w),
        .w_address(w_address), .cnta(cnta), .node_done(node_done),
        .layer_err(layer_err), .sat_cnt(sat_cnt)
    );

    typedef struct {
        logic           we;
        logic           err;
        logic           nd;
        logic [4:0]     layer;
        logic [8:0]     addr;
        logic [3:0]     cnt;
        logic [15:0]    sc;
        logic [2*W-1:0] b;
        logic           chk_b;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    int   msc = 0;

    int sbl[P], sbr[P], sll[P], slr[P];
    int pbl[P], pbr[P], pll[P], plr[P];
    bit pend_v = 1'b0;
    int p_layer, p_addr, p_cnt;
    bit p_last;

    function automatic void chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endfunction

    function automatic int clampi(input int x);
        return (x == -32) ? -31 : x;
    endfunction

    function automatic int sati(input int x);
        if (x > 31) return 31;
        if (x < -31) return -31;
        return x;
    endfunction

    function automatic int fms(input int a, input int b);
        int ma, mb, m;
        ma = (a < 0) ? -a : a;
        mb = (b < 0) ? -b : b;
        m  = (ma < mb) ? ma : mb;
        return ((a < 0) != (b < 0)) ? -m : m;
    endfunction

    // Expected outputs of the pending slot, with the sat_clr seen at its output edge.
    function automatic void retire(input bit clr);
        exp_t e;
        int   m, a, br, ll, lr, sum, s, lo, t, hi;
        bit   legal, ev;
        legal = 1'b0;
        ev    = 1'b0;
        if (pend_v) begin
            legal = (p_layer >= 1) && (p_layer <= 8);
            if (p_layer <= 1) m = 1;
            else if (p_layer >= 7) m = P;
            else m = 1 << (p_layer - 1);
            e.b = '0;
            for (int i = 0; i < m; i++) begin
                a   = clampi(pbl[i]);
                br  = clampi(pbr[i]);
                ll  = clampi(pll[i]);
                lr  = clampi(plr[i]);
                sum = br + lr;
                s   = sati(sum);
                lo  = fms(a, s);
                t   = fms(a, ll) + br;
                hi  = sati(t);
                if (s != sum || hi != t) ev = 1'b1;
                e.b[i*Q +: Q]     = lo[Q-1:0];
                e.b[W + i*Q +: Q] = hi[Q-1:0];
            end
            e.we    = legal;
            e.err   = !legal;
            e.nd    = legal && p_last;
            e.layer = p_layer[4:0];
            e.addr  = p_addr[8:0];
            e.cnt   = p_cnt[3:0];
            e.chk_b = legal;
        end
        if (clr) msc = 0;
        else if (pend_v && legal && ev && msc < 65535) msc++;
        if (pend_v) begin
            e.sc = msc[15:0];
            q.push_back(e);
        end
    endfunction

    task automatic drive(input bit v, input int layer, input int addr, input int cnt,
                         input bit last, input bit clr);
        retire(clr);
        in_valid   = v;
        in_layer   = layer[4:0];
        in_address = addr[8:0];
        in_cnt     = cnt[3:0];
        in_last    = last;
        sat_clr    = clr;
        for (int i = 0; i < P; i++) begin
            beta_l[i*Q +: Q] = sbl[i][Q-1:0];
            beta_r[i*Q +: Q] = sbr[i][Q-1:0];
            llr_l[i*Q +: Q]  = sll[i][Q-1:0];
            llr_r[i*Q +: Q]  = slr[i][Q-1:0];
            pbl[i] = sbl[i];
            pbr[i] = sbr[i];
            pll[i] = sll[i];
            plr[i] = slr[i];
        end
        pend_v  = v;
        p_layer = layer;
        p_addr  = addr;
        p_cnt   = cnt;
        p_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int bl, input int br, input int ll, input int lr);
        for (int i = 0; i < P; i++) begin
            sbl[i] = bl; sbr[i] = br; sll[i] = ll; slr[i] = lr;
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (w_en || layer_err) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_out", {w_en, layer_err}, 2'b00);
                end else begin
                    e = q.pop_front();
                    chk("sb_w_en", w_en, e.we);
                    chk("sb_layer_err", layer_err, e.err);
                    chk("sb_node_done", node_done, e.nd);
                    chk("sb_layer_w", layer_w, e.layer);
                    chk("sb_w_address", w_address, e.addr);
                    chk("sb_cnta", cnta, e.cnt);
                    chk("sb_sat_cnt", sat_cnt, e.sc);
                    if (e.chk_b) chk("sb_b_out", b_out, e.b);
                end
            end else begin
                chk("bubble_b_out", b_out, '0);
                chk("bubble_node_done", node_done, 1'b0);
            end
        end
    end

    initial begin
        int r, lay, mode, lim;
        set_all(0, 0, 0, 0);
        #12;
        chk("rst_w_en", w_en, 1'b0);
        chk("rst_b_out", b_out, '0);
        chk("rst_sat_cnt", sat_cnt, 16'd0);
        chk("rst_layer_err", layer_err, 1'b0);
        chk("rst_node_done", node_done, 1'b0);
        rst = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1);

        // Arithmetic
        set_all(5, 4, 10, -7);
        drive(1'b1, 8, 17, 2, 1'b0, 1'b0);
        set_all(0, 0, 0, 0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("arith_w_en", w_en, 1'b1);
        chk("arith_lo0", b_out[5:0], 6'h3D);
        chk("arith_lo63", b_out[63*Q +: Q], 6'h3D);
        chk("arith_hi0", b_out[W +: Q], 6'd9);
        chk("arith_sat_cnt", sat_cnt, 16'd0);

        // Saturation, then the -32 alias of -31
        set_all(-31, 31, -31, 20);
        drive(1'b1, 8, 1, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("sat_lo", b_out[5:0], 6'h21);
        chk("sat_hi", b_out[W +: Q], 6'h1F);
        chk("sat_cnt_1", sat_cnt, 16'd1);
        set_all(-32, 31, -32, 20);
        drive(1'b1, 8, 1, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("neg32_lo", b_out[5:0], 6'h21);
        chk("neg32_hi", b_out[W +: Q], 6'h1F);
        chk("sat_cnt_2", sat_cnt, 16'd2);

        // Masking at layer 2
        set_all(5, 4, 10, -7);
        drive(1'b1, 2, 5, 1, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("mask_lo1", b_out[1*Q +: Q], 6'h3D);
        chk("mask_hi1", b_out[W + 1*Q +: Q], 6'd9);
        chk("mask_lo2", b_out[2*Q +: Q], 6'd0);
        chk("mask_hi2", b_out[W + 2*Q +: Q], 6'd0);

        // Streaming a 4-chunk node
        drive(1'b1, 4, 3, 0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (k < 3) drive(1'b1, 4, 3, k + 1, (k == 2), 1'b0);
            else drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
            chk("stream_w_en", w_en, 1'b1);
            chk("stream_cnta", cnta, k[3:0]);
            chk("stream_addr", w_address, 9'd3);
            chk("stream_node_done", node_done, (k == 3));
        end
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("stream_bubble_w_en", w_en, 1'b0);

        // Illegal layer
        drive(1'b1, 9, 7, 0, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("err_pulse", layer_err, 1'b1);
        chk("err_w_en", w_en, 1'b0);
        chk("err_node_done", node_done, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("err_pulse_end", layer_err, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            mode = int'($urandom_range(0, 3));
            lim  = (mode == 0) ? 8 : 32;
            for (int i = 0; i < P; i++) begin
                sbl[i] = int'($urandom_range(0, 2 * lim - 1)) - lim;
                sbr[i] = int'($urandom_range(0, 2 * lim - 1)) - lim;
                sll[i] = int'($urandom_range(0, 2 * lim - 1)) - lim;
                slr[i] = int'($urandom_range(0, 2 * lim - 1)) - lim;
            end
            r = int'($urandom_range(0, 19));
            if (r < 16) lay = (r % 8) + 1;
            else if (r == 16) lay = 0;
            else lay = int'($urandom_range(9, 31));
            drive(($urandom_range(0, 4) != 0), lay, int'($urandom_range(0, 511)),
                  int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 31) == 0);
        end

        // Counter saturation at all-ones
        set_all(-31, 31, -31, 20);
        for (int n = 0; n < 65540; n++) drive(1'b1, 8, 0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("sat_cnt_hold", sat_cnt, 16'hFFFF);

        // Clear beats a simultaneous increment
        drive(1'b1, 8, 0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1);
        chk("clr_w_en", w_en, 1'b1);
        chk("clr_prio", sat_cnt, 16'd0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("sb_drained", q.size(), 0);

        // Reset mid-flight
        mon_en = 1'b0;
        set_all(5, 4, 10, -7);
        drive(1'b1, 8, 9, 1, 1'b1, 1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstmid_w_en", w_en, 1'b0);
        chk("rstmid_b_out", b_out, '0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        pend_v = 1'b0;
        q.delete();
        msc = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
            chk("rst_no_write", w_en, 1'b0);
            chk("rst_no_data", b_out, '0);
        end

        // Asynchronous drop while a write is on the port
        set_all(-31, 31, -31, 20);
        drive(1'b1, 8, 9, 1, 1'b1, 1'b0);
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("pre_rst_w_en", w_en, 1'b1);
        chk("pre_rst_sat", sat_cnt, 16'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_w_en", w_en, 1'b0);
        chk("async_b_out", b_out, '0);
        chk("async_node_done", node_done, 1'b0);
        chk("async_sat_cnt", sat_cnt, 16'd0);
        #3;
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
